fifo_rr_merge: RTL and testbench
================================

FIFO_RR_MERGE -- requirements
Module: fifo_rr_merge

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of producer channels (legal range 2..16, need not be a power of 2).
REQ-002 SHALL have parameter DATA_W, default 8, payload width per channel.
REQ-003 SHALL derive localparam TAG_W = $clog2(N_CH) and OUT_W = TAG_W + DATA_W.
REQ-004 Port list, one clock, synchronous active-high reset:
- clk  in  1  sole clock, all state on rising edge.
- srst  in  1  synchronous reset, active-high.
- in_valid  in  N_CH  per-channel data-valid.
- in_data  in  N_CH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- in_ready  out  N_CH  per-channel accept strobe.
- fifo_wr_en  out  1  write strobe to downstream fifo_fwft.
- fifo_din  out  OUT_W  {tag, payload}; tag in the MSBs.
- fifo_full  in  1  downstream full flag.
- idle  out  1  no held word and no in_valid asserted.

Function
REQ-005 SHALL merge N_CH valid/ready producers into one downstream fifo_fwft write port, one word per cycle maximum.
REQ-006 SHALL hold one output word in a register (hold_valid, hold_tag, hold_data); fifo_din SHALL equal {hold_tag, hold_data}.
REQ-007 fifo_wr_en SHALL equal hold_valid & !fifo_full, combinationally; the block never writes while fifo_full=1.
REQ-008 load_en SHALL equal !hold_valid | fifo_wr_en (register empty or draining this cycle).
REQ-009 Arbitration SHALL be round-robin: grant goes to the first channel with in_valid=1 searching from rr_ptr upward, wrapping at N_CH-1 -> 0.
REQ-010 in_ready[i] SHALL be 1 only for the granted channel and only when load_en=1; at most one bit of in_ready is high per cycle.
REQ-011 A transfer on channel i occurs when in_valid[i] & in_ready[i]; the register loads tag=i, data=in_data[i] on that edge, hold_valid<=1.
REQ-012 rr_ptr SHALL become (i+1) mod N_CH after a transfer from channel i and SHALL be unchanged on cycles with no transfer.
REQ-013 If fifo_wr_en=1 and no transfer occurs, hold_valid SHALL clear on the same edge.
REQ-014 Latency: word accepted at edge t is presented with fifo_wr_en=1 in the cycle after t when fifo_full=0; sustained throughput 1 word/cycle.
REQ-015 While fifo_full=1 with hold_valid=1: register, tag and rr_ptr SHALL stay stable and in_ready SHALL be all zero.
REQ-016 Simultaneous drain and load in one cycle SHALL lose no word and duplicate no word.
REQ-017 in_data/in_valid of non-granted channels SHALL be ignored; producers may drop in_valid at any time without effect.
REQ-018 idle SHALL equal !hold_valid & ~|in_valid.

Reset
REQ-019 On srst=1 at an edge: hold_valid<=0, rr_ptr<=0, hold_tag/hold_data<=0.
REQ-020 While srst=1, in_ready SHALL be all zero and fifo_wr_en SHALL be 0 regardless of other inputs.
REQ-021 Reset mid-operation SHALL discard any held word; first grant after reset starts from channel 0.

Structure
REQ-022 Shared package fifo_merge_pkg SHALL hold default N_CH, DATA_W and the TAG_W/OUT_W derivation used by producer and consumer blocks.
REQ-023 Arbitration SHALL be a sub-module rr_arbiter (inputs req, ptr, enable; outputs one-hot grant, grant index, grant_valid); pointer register stays in fifo_rr_merge.
REQ-024 Implementation SHALL be synthesizable and Verilator-lint clean, no latches, no multi-driven nets.

Verification (N_CH=4, DATA_W=8, downstream fifo_fwft DEPTH=16)
REQ-025 Single channel: in_valid=0b0100, data 0x3C, fifo_full=0 -> in_ready=0b0100 same cycle; next cycle fifo_wr_en=1, fifo_din=0x23C.
REQ-026 All channels valid continuously, payload = channel index -> fifo receives tags 0,1,2,3,0,1,... one per cycle, no gaps.
REQ-027 Backpressure: fill fifo to full, keep in_valid=0b1111 -> fifo_wr_en=0, in_ready=0, held word unchanged; release one read -> held word written, then next tag in RR order.
REQ-028 Wrap/pointer: transfer from channel 3 then in_valid=0b0011 -> channel 0 granted, then 1.
REQ-029 Reset mid-stream: assert srst with hold_valid=1 -> fifo_wr_en=0 during reset, hold_valid=0 after; first grant with in_valid=0b1010 goes to channel 1.
REQ-030 Scoreboard: random in_valid/fifo_full for 10000 cycles -> per-channel order preserved, word count in = words out + held, no word written while full.

Source files
------------

// File: rtl/fifo_merge_pkg.sv
// Shared defaults and width derivation for the round-robin merge block and
// whatever consumes its {tag, payload} words downstream.
package fifo_merge_pkg;

    localparam int unsigned DEF_N_CH   = 4;
    localparam int unsigned DEF_DATA_W = 8;

    function automatic int unsigned tag_width(input int unsigned n_ch);
        return $clog2(n_ch);
    endfunction

    function automatic int unsigned out_width(input int unsigned n_ch,
                                              input int unsigned data_w);
        return tag_width(n_ch) + data_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
// The pointer register lives in the parent so it can be frozen under backpressure.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_valid
);

    int unsigned      sum_c;
    logic [PTR_W-1:0] idx_c;
    logic             found_c;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        found_c     = 1'b0;
        sum_c       = 0;
        idx_c       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum_c = 32'(ptr) + k;
            idx_c = (sum_c >= N) ? PTR_W'(sum_c - N) : PTR_W'(sum_c);
            if (!found_c && req[idx_c]) begin
                found_c   = 1'b1;
                grant_idx = idx_c;
            end
        end
        if (enable && found_c) begin
            grant       = N'(1) << grant_idx;
            grant_valid = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rr_merge.sv
// Merges N_CH valid/ready producers into a single FWFT FIFO write port through a
// one-word holding register, arbitrating round-robin between requesters.
module fifo_rr_merge
    import fifo_merge_pkg::*;
#(
    parameter  int unsigned N_CH   = DEF_N_CH,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    localparam int unsigned TAG_W  = tag_width(N_CH),
    localparam int unsigned OUT_W  = out_width(N_CH, DATA_W)
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     fifo_wr_en,
    output logic [OUT_W-1:0]         fifo_din,
    input  logic                     fifo_full,
    output logic                     idle
);

    logic              hold_valid_q, hold_valid_d;
    logic [TAG_W-1:0]  hold_tag_q,   hold_tag_d;
    logic [DATA_W-1:0] hold_data_q,  hold_data_d;
    logic [TAG_W-1:0]  rr_ptr_q,     rr_ptr_d;

    logic              load_en;
    logic [N_CH-1:0]   grant;
    logic [TAG_W-1:0]  grant_idx;
    logic              grant_valid;
    logic [DATA_W-1:0] ch_data [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Reset gates both strobes so nothing moves while srst is held.
    assign fifo_wr_en = hold_valid_q & ~fifo_full & ~srst;
    assign load_en    = ~hold_valid_q | fifo_wr_en;
    assign fifo_din   = {hold_tag_q, hold_data_q};
    assign in_ready   = grant;
    assign idle       = ~hold_valid_q & ~|in_valid;

    rr_arbiter #(
        .N     (N_CH),
        .PTR_W (TAG_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr_q),
        .enable      (load_en & ~srst),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        hold_data_d  = hold_data_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant_valid) begin
            hold_valid_d = 1'b1;
            hold_tag_d   = grant_idx;
            hold_data_d  = ch_data[grant_idx];
            rr_ptr_d     = (grant_idx == TAG_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end else if (fifo_wr_en) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            hold_valid_q <= 1'b0;
            hold_tag_q   <= '0;
            hold_data_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Directed and random checks of fifo_rr_merge against a queue-based model of
// the merge behaviour plus a per-channel scoreboard.
module tb_fifo_rr_merge;

    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        fifo_wr_en;
    logic [11:0] fifo_din;
    logic        fifo_full;
    logic        idle;

    fifo_rr_merge #(.N_CH(4), .DATA_W(8)) dut (
        .clk        (clk),
        .srst       (srst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: held word, its tag/payload, RR pointer.
    bit         m_held = 0;
    logic [1:0] m_tag  = '0;
    logic [7:0] m_data = '0;
    int         m_ptr  = 0;
    logic [7:0] sb [4][$];
    int         wr_log [$];
    int         in_cnt = 0, out_cnt = 0, occ = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at posedge+1; outputs are checked at the negedge,
    // then the model advances to the state after the coming posedge.
    task automatic cycle();
        logic [3:0] exp_rdy;
        logic       exp_wr, exp_load;
        int         g;
        @(negedge clk);
        exp_wr   = !srst && m_held && !fifo_full;
        exp_load = !m_held || exp_wr;
        g = -1;
        if (!srst && exp_load)
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (g < 0 && in_valid[c]) g = c;
            end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", in_ready, exp_rdy);
        chk("wr_en", fifo_wr_en, exp_wr);
        chk("idle", idle, !m_held && in_valid == 4'b0000);
        chk("wr_while_full", fifo_wr_en & fifo_full, 0);
        if (m_held) chk("din", fifo_din, {m_tag, m_data});
        if (exp_wr) begin
            wr_log.push_back(int'(m_tag));
            out_cnt++;
            occ++;
            if (sb[m_tag].size() > 0) chk("order", fifo_din[7:0], sb[m_tag].pop_front());
        end
        if (srst) begin
            if (m_held) void'(sb[m_tag].pop_back());
            m_held = 0; m_tag = '0; m_data = '0; m_ptr = 0;
        end else if (g >= 0) begin
            m_held = 1;
            m_tag  = 2'(g);
            m_data = in_data[g*8 +: 8];
            sb[g].push_back(m_data);
            in_cnt++;
            m_ptr  = (g + 1) % 4;
        end else if (exp_wr) begin
            m_held = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        cycle();
        srst = 1'b0;
    endtask

    initial begin
        srst = 1'b1; in_valid = 4'hF; in_data = 32'h0; fifo_full = 1'b0;
        cycle();
        cycle();
        srst = 1'b0; in_valid = 4'h0;
        #2;
        chk("rst_din", fifo_din, 12'h000);
        chk("rst_idle", idle, 1);
        cycle();

        // Single channel 2 word
        in_valid = 4'b0100; in_data = 32'hA5_3C_77_11;
        #2 chk("single_ready", in_ready, 4'b0100);
        cycle();
        in_valid = 4'b0000;
        #2;
        chk("single_wr", fifo_wr_en, 1);
        chk("single_din", fifo_din, 12'h23C);
        cycle();

        // All channels valid: tags 0,1,2,3,... with no gaps
        do_reset();
        wr_log.delete();
        in_valid = 4'hF; in_data = 32'h03_02_01_00;
        repeat (12) cycle();
        in_valid = 4'h0;
        cycle();
        chk("stream_count", wr_log.size(), 12);
        foreach (wr_log[k]) chk("stream_tag", wr_log[k], k % 4);

        // Backpressure from a depth-16 downstream FIFO, then two single reads
        do_reset();
        wr_log.delete();
        occ = 0;
        in_valid = 4'hF;
        for (int k = 0; k < 24; k++) begin
            fifo_full = (occ >= 16);
            cycle();
        end
        fifo_full = (occ >= 16);
        #2 chk("bp_ready", in_ready, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            if (k == 0 || k == 2) occ--;
            fifo_full = (occ >= 16);
            cycle();
        end
        chk("bp_count", wr_log.size(), 18);
        foreach (wr_log[k]) chk("bp_tag", wr_log[k], k % 4);
        fifo_full = 1'b0; in_valid = 4'h0;
        cycle();
        cycle();

        // Pointer wrap from channel 3
        do_reset();
        in_valid = 4'b1000;
        #2 chk("wrap_ready3", in_ready, 4'b1000);
        cycle();
        in_valid = 4'b0011;
        #2 chk("wrap_ready0", in_ready, 4'b0001);
        cycle();
        #2 chk("wrap_ready1", in_ready, 4'b0010);
        cycle();
        in_valid = 4'b0000;
        cycle();
        cycle();

        // Reset with a held word stalled behind a full FIFO
        fifo_full = 1'b1; in_valid = 4'b0001; in_data = 32'h44_33_22_11;
        cycle();
        cycle();
        srst = 1'b1; fifo_full = 1'b0; in_valid = 4'hF;
        #2;
        chk("mrst_wr", fifo_wr_en, 0);
        chk("mrst_ready", in_ready, 4'b0000);
        cycle();
        srst = 1'b0; in_valid = 4'b0000;
        #2 chk("mrst_idle", idle, 1);
        in_valid = 4'b1010;
        #1 chk("mrst_grant", in_ready, 4'b0010);
        cycle();
        in_valid = 4'b0000;
        cycle();

        // Random traffic and backpressure
        do_reset();
        in_cnt = 0; out_cnt = 0;
        for (int k = 0; k < 10000; k++) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            fifo_full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        chk("conserve", in_cnt, out_cnt + int'(m_held));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
